// File: rtl/ps2_kbd_pkg.sv
// Shared state type and scan-code constants for the PS/2 keyboard sequencer.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } seq_state_t;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_ACK = 8'hFA;
  localparam logic [7:0] SC_BAT = 8'hAA;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Inter-byte timeout counter: counts while a sequence is open, flags expiry at
// TIMEOUT_CYCLES-1 and holds there until cleared.
module seq_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/scancode_sequencer.sv
// PS/2 scan-code parser: turns make/break byte sequences into push and release strobes.
// Optional typematic repeat suppression is built when REPEAT_FILTER_EN is defined.
import ps2_kbd_pkg::*;

module scancode_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_error,
  output logic       push,
  output logic [7:0] push_code,
  output logic       push_ext,
  output logic       key_released,
  output logic [7:0] release_code,
  output logic       seq_timeout,
  output logic       busy
);

  seq_state_t state;
  seq_state_t next_state;
  logic       make_done;
  logic       brk_done;
  logic       tmo_hit;
  logic       seq_ext;
  logic       expired;
  logic       repeat_hit;
  logic       do_push;

  seq_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid || (state == IDLE)),
    .run    (state != IDLE),
    .expired(expired)
  );

  // Errors outrank bytes, and a byte arriving on the expiry cycle outranks the timeout.
  always_comb begin
    next_state = state;
    make_done  = 1'b0;
    brk_done   = 1'b0;
    tmo_hit    = 1'b0;
    seq_ext    = (state == EXT) || (state == EXT_BRK);
    if (rx_error) begin
      next_state = IDLE;
    end else if (rx_valid) begin
      unique case (state)
        IDLE: begin
          if (rx_byte == SC_EXT)      next_state = EXT;
          else if (rx_byte == SC_BRK) next_state = BRK;
          else if (rx_byte != SC_ACK && rx_byte != SC_BAT) make_done = 1'b1;
        end
        EXT: begin
          if (rx_byte == SC_BRK)      next_state = EXT_BRK;
          else if (rx_byte == SC_EXT) next_state = EXT;
          else begin
            make_done  = 1'b1;
            next_state = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          brk_done   = !is_prefix(rx_byte);
          next_state = IDLE;
        end
      endcase
    end else if (expired) begin
      next_state = IDLE;
      tmo_hit    = 1'b1;
    end
  end

`ifdef REPEAT_FILTER_EN
  logic [8:0] last_make;

  assign repeat_hit = ({seq_ext, rx_byte} == last_make);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_make <= '0;
    end else if (make_done && !repeat_hit) begin
      last_make <= {seq_ext, rx_byte};
    end else if (brk_done && repeat_hit) begin
      last_make <= '0;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  assign do_push = make_done && !repeat_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      push         <= 1'b0;
      push_code    <= '0;
      push_ext     <= 1'b0;
      key_released <= 1'b0;
      release_code <= '0;
      seq_timeout  <= 1'b0;
    end else begin
      state        <= next_state;
      push         <= do_push;
      key_released <= brk_done;
      seq_timeout  <= tmo_hit;
      if (do_push) begin
        push_code <= rx_byte;
        push_ext  <= seq_ext;
      end
      if (brk_done) begin
        release_code <= rx_byte;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
